fifo_pattern_writer: RTL and testbench

- Write-side traffic source for the host-read test FIFO.
- Pushes an incrementing data pattern into the FIFO write port.
- Backs off for a fixed hold window whenever prog_full asserts, including the periodic prog_full pulse from the prog_full generator stage.
- Lets the host side check stream continuity and measure throttling behaviour.

---
 rtl/fifo_pattern_writer_pkg.sv | 14 +
 rtl/fifo_pattern_writer_sat_counter.sv | 19 +
 rtl/fifo_pattern_writer.sv | 101 ++++++++++
 tb/tb_fifo_pattern_writer.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pattern_writer_pkg.sv
// Shared definitions for the FIFO pattern writer and related test-traffic blocks.
package fifo_pattern_writer_pkg;

    localparam int DEFAULT_DATA_W = 32;
    localparam logic [15:0] SAT_LIMIT = 16'hFFFF;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_HOLD = 2'd2;
    localparam state_t ST_DONE = 2'd3;

endpackage

// File: rtl/fifo_pattern_writer_sat_counter.sv
// 16-bit incrementer that sticks at SAT_LIMIT instead of wrapping.
module sat_counter
    import fifo_pattern_writer_pkg::*;
(
    input  logic        prg_clk,
    input  logic        rst,
    input  logic        inc,
    output logic [15:0] count
);

    always_ff @(posedge prg_clk or posedge rst) begin
        if (rst) begin
            count <= 16'd0;
        end else if (inc && (count != SAT_LIMIT)) begin
            count <= count + 16'd1;
        end
    end

endmodule

// File: rtl/fifo_pattern_writer.sv
// Write-side traffic source: pushes an incrementing pattern into a FIFO and
// backs off for a hold window whenever prog_full is raised.
module fifo_pattern_writer
    import fifo_pattern_writer_pkg::*;
#(
    parameter int                DATA_W      = DEFAULT_DATA_W,
    parameter logic [DATA_W-1:0] SEED        = '0,
    parameter int                HOLD_CYCLES = 16,
    parameter int                MAX_WORDS   = 0,
    parameter int                CNT_W       = 32
) (
    input  logic              prg_clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              prog_full,
    input  logic              fifo_full,
    output logic [DATA_W-1:0] fifo_din,
    output logic              fifo_wr_en,
    output logic [CNT_W-1:0]  words_written,
    output logic [15:0]       stall_cycles,
    output logic              holding,
    output logic              done
);

    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

    state_t             state;
    logic [DATA_W-1:0]  pattern;
    logic [HOLD_W-1:0]  hold_cnt;
    logic [CNT_W-1:0]   words_inc;
    logic               max_hit;
    logic               stall_inc;

    assign fifo_wr_en = (state == ST_RUN) && !fifo_full;
    assign fifo_din   = pattern;
    assign holding    = (state == ST_HOLD);
    assign done       = (state == ST_DONE);
    assign words_inc  = words_written + CNT_W'(1);
    assign max_hit    = (MAX_WORDS != 0) && (words_inc == CNT_W'(MAX_WORDS));
    assign stall_inc  = (state == ST_HOLD) || ((state == ST_RUN) && fifo_full);

    // A write accepted on the same edge as prog_full still completes; the
    // prog_full threshold leaves room for it before the FSM backs off.
    always_ff @(posedge prg_clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            pattern       <= SEED;
            words_written <= '0;
            hold_cnt      <= '0;
        end else begin
            if (fifo_wr_en) begin
                pattern       <= pattern + DATA_W'(1);
                words_written <= words_inc;
            end
            case (state)
                ST_IDLE: begin
                    if (enable) begin
                        state         <= ST_RUN;
                        words_written <= '0;
                    end
                end
                ST_RUN: begin
                    if (!enable) begin
                        state <= ST_IDLE;
                    end else if (fifo_wr_en && max_hit) begin
                        state <= ST_DONE;
                    end else if (prog_full) begin
                        state    <= ST_HOLD;
                        hold_cnt <= HOLD_LOAD;
                    end
                end
                ST_HOLD: begin
                    if (!enable) begin
                        state <= ST_IDLE;
                    end else if (hold_cnt == '0) begin
                        if (!prog_full) begin
                            state <= ST_RUN;
                        end
                    end else begin
                        hold_cnt <= hold_cnt - HOLD_W'(1);
                    end
                end
                ST_DONE: begin
                    if (!enable) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    sat_counter u_stall_counter (
        .prg_clk (prg_clk),
        .rst     (rst),
        .inc     (stall_inc),
        .count   (stall_cycles)
    );

endmodule

// File: tb/tb_fifo_pattern_writer.sv
// Scoreboard bench: two writer instances (unlimited run / limited run with wrapping seed).
module tb_fifo_pattern_writer;

    logic prg_clk = 1'b0;
    logic rst     = 1'b1;
    always #5 prg_clk = ~prg_clk;

    logic        enable_a = 1'b0, prog_full_a = 1'b0, fifo_full_a = 1'b0;
    logic [31:0] din_a, words_a;
    logic [15:0] stall_a;
    logic        wr_en_a, holding_a, done_a;

    logic        enable_b = 1'b0, prog_full_b = 1'b0, fifo_full_b = 1'b0;
    logic [31:0] din_b, words_b;
    logic [15:0] stall_b;
    logic        wr_en_b, holding_b, done_b;

    int vectors     = 0;
    int miscompares = 0;
    int wr_cnt_a    = 0;
    int wr_cnt_b    = 0;

    logic [31:0] qa[$];
    logic [31:0] qb[$];
    logic [31:0] model_a = 32'h0;
    logic [31:0] model_b = 32'hFFFF_FFFE;
    logic [15:0] stall_model_a = 16'd0;

    fifo_pattern_writer #(
        .DATA_W(32), .SEED(32'h0), .HOLD_CYCLES(16), .MAX_WORDS(0), .CNT_W(32)
    ) dut_a (
        .prg_clk(prg_clk), .rst(rst), .enable(enable_a), .prog_full(prog_full_a),
        .fifo_full(fifo_full_a), .fifo_din(din_a), .fifo_wr_en(wr_en_a),
        .words_written(words_a), .stall_cycles(stall_a), .holding(holding_a), .done(done_a)
    );

    fifo_pattern_writer #(
        .DATA_W(32), .SEED(32'hFFFF_FFFE), .HOLD_CYCLES(4), .MAX_WORDS(4), .CNT_W(32)
    ) dut_b (
        .prg_clk(prg_clk), .rst(rst), .enable(enable_b), .prog_full(prog_full_b),
        .fifo_full(fifo_full_b), .fifo_din(din_b), .fifo_wr_en(wr_en_b),
        .words_written(words_b), .stall_cycles(stall_b), .holding(holding_b), .done(done_b)
    );

    // Every write strobe seen before the next rising edge must match the oldest expected word.
    initial begin
        logic [31:0] exp_word;
        forever begin
            @(negedge prg_clk);
            #2;
            if (wr_en_a !== 1'b0) begin
                vectors++;
                wr_cnt_a++;
                if (qa.size() == 0) begin
                    miscompares++;
                    $display("[TB] FAIL write_a: unexpected write din=%h, required no write", din_a);
                end else begin
                    exp_word = qa.pop_front();
                    if (din_a !== exp_word) begin
                        miscompares++;
                        $display("[TB] FAIL data_a: got %h, required %h", din_a, exp_word);
                    end
                end
            end
            if (wr_en_b !== 1'b0) begin
                vectors++;
                wr_cnt_b++;
                if (qb.size() == 0) begin
                    miscompares++;
                    $display("[TB] FAIL write_b: unexpected write din=%h, required no write", din_b);
                end else begin
                    exp_word = qb.pop_front();
                    if (din_b !== exp_word) begin
                        miscompares++;
                        $display("[TB] FAIL data_b: got %h, required %h", din_b, exp_word);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish, required completion");
        $fatal(1, "[TB] timeout");
    end

    task test_reset;
        @(negedge prg_clk);
        vectors++;
        if ({wr_en_a, holding_a, done_a, wr_en_b, holding_b, done_b} !== 6'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_flags: got %b, required 000000",
                     {wr_en_a, holding_a, done_a, wr_en_b, holding_b, done_b});
        end
        vectors++;
        if (words_a !== 32'h0 || stall_a !== 16'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_counts_a: got words=%0d stall=%0d, required 0/0", words_a, stall_a);
        end
        vectors++;
        if (din_a !== 32'h0 || din_b !== 32'hFFFF_FFFE) begin
            miscompares++;
            $display("[TB] FAIL reset_seed: got %h/%h, required 00000000/fffffffe", din_a, din_b);
        end
        rst = 1'b0;
        @(negedge prg_clk);
        vectors++;
        if (wr_en_a !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL idle_wr_en: got %b, required 0", wr_en_a);
        end
    endtask

    task test_stream;
        enable_a = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge prg_clk);
            if (i == 0) begin
                vectors++;
                if (wr_en_a !== 1'b1) begin
                    miscompares++;
                    $display("[TB] FAIL first_write_latency: wr_en=%b, required 1", wr_en_a);
                end
            end
            qa.push_back(model_a);
            model_a = model_a + 32'd1;
            if (i == 9) enable_a = 1'b0;
        end
        @(negedge prg_clk);
        vectors++;
        if (words_a !== 32'd10 || wr_en_a !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL stream_words: got words=%0d wr_en=%b, required 10/0", words_a, wr_en_a);
        end
    endtask

    task test_prog_full_pulse;
        int cnt;
        enable_a = 1'b1;
        @(negedge prg_clk);
        vectors++;
        if (words_a !== 32'd0) begin
            miscompares++;
            $display("[TB] FAIL restart_words: got %0d, required 0", words_a);
        end
        qa.push_back(model_a);
        model_a = model_a + 32'd1;
        prog_full_a = 1'b1;
        @(negedge prg_clk);
        prog_full_a = 1'b0;
        cnt = 0;
        while (holding_a === 1'b1 && cnt < 100) begin
            cnt++;
            @(negedge prg_clk);
        end
        vectors++;
        if (cnt != 16) begin
            miscompares++;
            $display("[TB] FAIL hold_window: got %0d cycles, required 16", cnt);
        end
        stall_model_a = stall_model_a + 16'd16;
        vectors++;
        if (wr_en_a !== 1'b1 || stall_a !== stall_model_a) begin
            miscompares++;
            $display("[TB] FAIL hold_resume: got wr_en=%b stall=%0d, required 1/%0d",
                     wr_en_a, stall_a, stall_model_a);
        end
        qa.push_back(model_a);
        model_a = model_a + 32'd1;
    endtask

    task test_prog_full_long;
        int hc;
        int wr0;
        hc = 0;
        wr0 = 0;
        prog_full_a = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge prg_clk);
            if (i == 1) wr0 = wr_cnt_a;
            if (holding_a === 1'b1 && wr_en_a === 1'b0) hc++;
            if (i == 40) prog_full_a = 1'b0;
        end
        @(negedge prg_clk);
        vectors++;
        if (hc != 40) begin
            miscompares++;
            $display("[TB] FAIL long_hold: got %0d hold cycles, required 40", hc);
        end
        vectors++;
        if (wr_cnt_a != wr0) begin
            miscompares++;
            $display("[TB] FAIL long_hold_writes: got %0d writes, required 0", wr_cnt_a - wr0);
        end
        stall_model_a = stall_model_a + 16'd40;
        vectors++;
        if (stall_a !== stall_model_a || wr_en_a !== 1'b1 || din_a !== model_a) begin
            miscompares++;
            $display("[TB] FAIL long_resume: got stall=%0d wr_en=%b din=%h, required %0d/1/%h",
                     stall_a, wr_en_a, din_a, stall_model_a, model_a);
        end
    endtask

    task test_fifo_full;
        fifo_full_a = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            @(negedge prg_clk);
            vectors++;
            if (wr_en_a !== 1'b0 || din_a !== model_a || holding_a !== 1'b0 || done_a !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL full_block: got wr_en=%b din=%h holding=%b done=%b, required 0/%h/0/0",
                         wr_en_a, din_a, holding_a, done_a, model_a);
            end
        end
        fifo_full_a = 1'b0;
        stall_model_a = stall_model_a + 16'd5;
        vectors++;
        if (stall_a !== stall_model_a) begin
            miscompares++;
            $display("[TB] FAIL full_stall: got %0d, required %0d", stall_a, stall_model_a);
        end
        qa.push_back(model_a);
        model_a = model_a + 32'd1;
        enable_a = 1'b0;
        @(negedge prg_clk);
        vectors++;
        if (words_a !== 32'd3 || wr_en_a !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL run2_words: got words=%0d wr_en=%b, required 3/0", words_a, wr_en_a);
        end
    endtask

    task test_max_words_wrap;
        enable_b = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge prg_clk);
            qb.push_back(model_b);
            model_b = model_b + 32'd1;
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge prg_clk);
            vectors++;
            if (done_b !== 1'b1 || wr_en_b !== 1'b0 || words_b !== 32'd4) begin
                miscompares++;
                $display("[TB] FAIL done_state: got done=%b wr_en=%b words=%0d, required 1/0/4",
                         done_b, wr_en_b, words_b);
            end
        end
        enable_b = 1'b0;
        @(negedge prg_clk);
        vectors++;
        if (done_b !== 1'b0 || words_b !== 32'd4) begin
            miscompares++;
            $display("[TB] FAIL idle_after_done: got done=%b words=%0d, required 0/4", done_b, words_b);
        end
        enable_b = 1'b1;
        @(negedge prg_clk);
        vectors++;
        if (words_b !== 32'd0 || din_b !== model_b) begin
            miscompares++;
            $display("[TB] FAIL rerun_start: got words=%0d din=%h, required 0/%h", words_b, din_b, model_b);
        end
        qb.push_back(model_b);
        model_b = model_b + 32'd1;
    endtask

    task test_reset_mid_run;
        @(negedge prg_clk);
        vectors++;
        if (words_b !== 32'd1 || wr_en_b !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL pre_reset_run: got words=%0d wr_en=%b, required 1/1", words_b, wr_en_b);
        end
        rst = 1'b1;
        #1;
        vectors++;
        if (wr_en_b !== 1'b0 || din_b !== 32'hFFFF_FFFE || words_b !== 32'd0 || done_b !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL async_reset: got wr_en=%b din=%h words=%0d done=%b, required 0/fffffffe/0/0",
                     wr_en_b, din_b, words_b, done_b);
        end
        vectors++;
        if (stall_a !== 16'd0 || din_a !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_clears_a: got stall=%0d din=%h, required 0/00000000", stall_a, din_a);
        end
        @(negedge prg_clk);
        enable_b = 1'b0;
        rst = 1'b0;
        @(negedge prg_clk);
    endtask

    initial begin
        test_reset();
        test_stream();
        test_prog_full_pulse();
        test_prog_full_long();
        test_fifo_full();
        test_max_words_wrap();
        test_reset_mid_run();
        vectors++;
        if (qa.size() != 0 || qb.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL missing_writes: got %0d/%0d words outstanding, required 0/0",
                     qa.size(), qb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
